// File: rtl/ofdm_bit_serializer.sv
// rtl/ofdm_bit_serializer.sv - symbol-word FIFO feeding a valid/ready serial bit stream
// Define OFDM_SER_MSB_FIRST_EN to emit each word MSB first (default LSB first).
module ofdm_bit_serializer #(
  parameter int FFT_SIZE = 16,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic [FFT_SIZE-1:0]          din,
  output logic                         dout_bit,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         dout_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int BW = $clog2(FFT_SIZE);
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(FFT_SIZE-1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              r_state, w_next_state;
  logic [FFT_SIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic                r_overflow;
  logic [FFT_SIZE-1:0] r_shift;
  logic [BW-1:0]       r_bcnt;
  logic                w_hs, w_pop, w_push, w_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // A pop on the final handshake reloads the shifter so words stream without a bubble
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_valid = 1'b1;
        if (dout_ready && (r_bcnt == LAST_BIT)) begin
          if (r_level != '0) w_pop = 1'b1;
          else               w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_hs   = w_valid & dout_ready;
  assign w_push = din_valid & ((r_level != FULL) | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      if (din_valid && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_bcnt  <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
      r_bcnt  <= '0;
    end else if (w_hs) begin
`ifdef OFDM_SER_MSB_FIRST_EN
      r_shift <= {r_shift[FFT_SIZE-2:0], 1'b0};
`else
      r_shift <= {1'b0, r_shift[FFT_SIZE-1:1]};
`endif
      r_bcnt  <= r_bcnt + BW'(1);
    end
  end

`ifdef OFDM_SER_MSB_FIRST_EN
  assign dout_bit = r_shift[FFT_SIZE-1];
`else
  assign dout_bit = r_shift[0];
`endif
  assign dout_valid = w_valid;
  assign dout_last  = w_valid & (r_bcnt == LAST_BIT);
  assign level      = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ofdm_bit_serializer.sv
// tb/tb_ofdm_bit_serializer.sv - bench for ofdm_bit_serializer
module tb_ofdm_bit_serializer;
  localparam int DEPTH = 4;

  logic        clk, rst, din_valid, dout_ready;
  logic [15:0] din;
  logic        dout_bit, dout_valid, dout_last, overflow;
  logic [2:0]  level;

  int total, bad;

  logic [15:0] m_fifo[$];
  logic        m_bits[$];
  logic        m_ovf;
  logic        cap_bits[$];
  logic        cap_last[$];

  typedef struct {
    logic [15:0] din;
    logic [15:0] seq;  // seq[j] = j-th bit emitted in LSB-first order
  } vec_t;
  vec_t vecs[5];

  ofdm_bit_serializer #(.FFT_SIZE(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .dout_bit(dout_bit), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .level(level), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic emit_bit(input logic [15:0] w, input int j);
`ifdef OFDM_SER_MSB_FIRST_EN
    return w[15-j];
`else
    return w[j];
`endif
  endfunction

  function automatic logic exp_seq(input logic [15:0] seq, input int j);
`ifdef OFDM_SER_MSB_FIRST_EN
    return seq[15-j];
`else
    return seq[j];
`endif
  endfunction

  task automatic model_step(input logic dv, input logic [15:0] d, input logic rdy);
    int          n;
    logic        hs, pop, push_ok;
    logic [15:0] w;
    n       = m_bits.size();
    hs      = (n > 0) && rdy;
    pop     = (m_fifo.size() > 0) && ((n == 0) || (hs && n == 1));
    push_ok = dv && ((m_fifo.size() < DEPTH) || pop);
    if (hs) void'(m_bits.pop_front());
    if (pop) begin
      w = m_fifo.pop_front();
      for (int j = 0; j < 16; j++) m_bits.push_back(emit_bit(w, j));
    end
    if (push_ok) m_fifo.push_back(d);
    else if (dv) m_ovf = 1'b1;
  endtask

  task automatic check_outputs();
    chk("valid", 32'(dout_valid), 32'(m_bits.size() > 0));
    chk("last", 32'(dout_last), 32'(m_bits.size() == 1));
    chk("level", 32'(level), 32'(m_fifo.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_bits.size() > 0) chk("bit", 32'(dout_bit), 32'(m_bits[0]));
  endtask

  task automatic cycle(input logic dv, input logic [15:0] d, input logic rdy);
    din_valid  = dv;
    din        = d;
    dout_ready = rdy;
    if (dout_valid && rdy) begin
      cap_bits.push_back(dout_bit);
      cap_last.push_back(dout_last);
    end
    model_step(dv, d, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain_until(input int n, input int budget);
    int b;
    b = budget;
    while (cap_bits.size() < n && b > 0) begin
      cycle(1'b0, 16'h0, 1'b1);
      b--;
    end
    if (cap_bits.size() < n) chk("drain_timeout", 32'(cap_bits.size()), 32'(n));
  endtask

  task automatic clear_cap();
    cap_bits.delete();
    cap_last.delete();
  endtask

  initial begin
    logic [15:0] ow[6];
    logic [15:0] fw[6];
    int          seen, bub;

    total = 0; bad = 0; m_ovf = 1'b0;
    vecs[0] = '{din: 16'hA5C3, seq: 16'hA5C3};
    vecs[1] = '{din: 16'hFFFF, seq: 16'hFFFF};
    vecs[2] = '{din: 16'h0000, seq: 16'h0000};
    vecs[3] = '{din: 16'h1234, seq: 16'h1234};
    vecs[4] = '{din: 16'h8001, seq: 16'h8001};
    ow = '{16'h8001, 16'h4002, 16'h2004, 16'h1008, 16'h0810, 16'hFFFF};
    fw = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h3C3C, 16'hBEEF};

    rst = 1'b0; din_valid = 1'b0; din = 16'h0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    chk("rst_bit", 32'(dout_bit), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    repeat (2) cycle(1'b0, 16'h0, 1'b1);

    // single words from the table
    for (int v = 0; v < 5; v++) begin
      clear_cap();
      cycle(1'b1, vecs[v].din, 1'b1);
      chk("lat_level1", 32'(level), 32'd1);
      chk("lat_valid0", 32'(dout_valid), 32'd0);
      cycle(1'b0, 16'h0, 1'b1);
      chk("lat_valid1", 32'(dout_valid), 32'd1);
      drain_until(16, 40);
      chk("single_after_valid", 32'(dout_valid), 32'd0);
      for (int j = 0; j < 16 && j < cap_bits.size(); j++) begin
        chk("single_seq", 32'(cap_bits[j]), 32'(exp_seq(vecs[v].seq, j)));
        chk("single_last", 32'(cap_last[j]), 32'(j == 15));
      end
    end

    // back-to-back words, no bubble
    clear_cap();
    cycle(1'b1, 16'hFFFF, 1'b1);
    cycle(1'b1, 16'h0000, 1'b1);
    seen = 0; bub = 0;
    for (int b = 0; b < 60 && cap_bits.size() < 32; b++) begin
      if (dout_valid) seen = 1;
      else if (seen != 0) bub++;
      cycle(1'b0, 16'h0, 1'b1);
    end
    chk("b2b_count", 32'(cap_bits.size()), 32'd32);
    chk("b2b_bubbles", 32'(bub), 32'd0);
    for (int j = 0; j < 32 && j < cap_bits.size(); j++) begin
      chk("b2b_bit", 32'(cap_bits[j]), 32'(j < 16));
      chk("b2b_last", 32'(cap_last[j]), 32'(j == 15 || j == 31));
    end

    // backpressure during bit 5
    clear_cap();
    cycle(1'b1, 16'h5A3C, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    drain_until(5, 20);
    repeat (10) begin
      cycle(1'b0, 16'h0, 1'b0);
      chk("bp_valid", 32'(dout_valid), 32'd1);
      chk("bp_bit", 32'(dout_bit), 32'(emit_bit(16'h5A3C, 5)));
      chk("bp_last", 32'(dout_last), 32'd0);
    end
    drain_until(16, 40);
    for (int j = 0; j < 16 && j < cap_bits.size(); j++)
      chk("bp_seq", 32'(cap_bits[j]), 32'(emit_bit(16'h5A3C, j)));

    // overflow: six words with consumer stalled
    for (int k = 0; k < 6; k++) cycle(1'b1, ow[k], 1'b0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    repeat (3) cycle(1'b0, 16'h0, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_cap();
    drain_until(80, 200);
    repeat (5) cycle(1'b0, 16'h0, 1'b1);
    chk("ovf_count", 32'(cap_bits.size()), 32'd80);
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 16; j++)
        if (k*16+j < cap_bits.size())
          chk("ovf_seq", 32'(cap_bits[k*16+j]), 32'(emit_bit(ow[k], j)));
    chk("ovf_still", 32'(overflow), 32'd1);

    // asynchronous reset with two words buffered
    cycle(1'b1, 16'h1357, 1'b0);
    cycle(1'b1, 16'h2468, 1'b0);
    cycle(1'b1, 16'h9ABC, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_last", 32'(dout_last), 32'd0);
    chk("arst_bit", 32'(dout_bit), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    m_fifo.delete(); m_bits.delete(); m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      cycle(1'b0, 16'h0, 1'b1);
      chk("post_rst_valid", 32'(dout_valid), 32'd0);
    end

    // full FIFO with a push on the shifter's last handshake
    for (int k = 0; k < 5; k++) cycle(1'b1, fw[k], 1'b0);
    chk("fs_level_full", 32'(level), 32'd4);
    clear_cap();
    repeat (15) cycle(1'b0, 16'h0, 1'b1);
    chk("fs_last", 32'(dout_last), 32'd1);
    cycle(1'b1, fw[5], 1'b1);
    chk("fs_level", 32'(level), 32'd4);
    chk("fs_ovf", 32'(overflow), 32'd0);
    drain_until(96, 200);
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 16; j++)
        if (k*16+j < cap_bits.size())
          chk("fs_seq", 32'(cap_bits[k*16+j]), 32'(emit_bit(fw[k], j)));

    // randomized traffic against the queue model
    for (int ph = 0; ph < 15; ph++) begin
      int rate, rdy_pct;
      rate    = $urandom_range(0, 15);
      rdy_pct = $urandom_range(30, 100);
      for (int c = 0; c < 200; c++)
        cycle(($urandom_range(0, 99) < rate), 16'($urandom), ($urandom_range(0, 99) < rdy_pct));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
